key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- Active scanner for a 4x4 matrix keypad: drives column lines low one at a time, samples the row lines and debounces each full scan frame.
- Emits one-cycle press and release events carrying a 4-bit key code.
- Sits at the board-pin end of the key path, beside the single-key debounce and LED driver path, and feeds the same LED/display logic.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven (dwell); minimum 2.
- DEB_SCANS, 4, consecutive identical frames required to accept a new key state; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row_in  input  4  keypad rows, active-low, externally pulled up, already synchronised
- col_out  output  4  column drive, active-low one-hot
- key_code  output  4  code of the reported key = 4*row + col
- key_valid  output  1  one-cycle press event
- key_release  output  1  one-cycle release event for the held key
- key_down  output  1  level; high while a reported single key is held

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, all applied immediately on rst:
  - col_out=4'b1110, key_code=0, key_valid=0, key_release=0, key_down=0.
  - Dwell counter=0, column index=0, snapshot/prev/debounced=0, stable count=0, FSM=S_IDLE.
- Scanning:
  - Dwell counter runs 0..SCAN_DIV-1; the column index advances 0->1->2->3->0 on wrap.
  - col_out = ~(1<<col).
  - At dwell count SCAN_DIV-1, sample rows: snap[4*r+col] = ~row_in[r].
  - Frame end = the sample cycle of column 3. Frame = 4*SCAN_DIV cycles.
- Debounce, evaluated at frame end only:
  - If snap==prev: cnt = min(cnt+1, DEB_SCANS-1); otherwise cnt = 0.
  - prev <= snap.
  - When the new cnt == DEB_SCANS-1, debounced <= snap.
  - A frame change therefore needs DEB_SCANS identical consecutive frames before acceptance.
- Event FSM, evaluated in the cycle after each frame end, using debounced:
  - S_IDLE:
    - Exactly one bit set -> key_code=index, key_valid=1 for one cycle, key_down=1, go to S_HELD.
    - More than one bit set -> S_BLOCK, no event.
    - Zero bits set -> stay.
  - S_HELD:
    - All clear -> key_release=1 for one cycle (key_code unchanged), key_down=0, go to S_IDLE.
    - Same single key -> stay, no event.
    - Any other non-zero pattern -> key_down=0, go to S_BLOCK, no release pulse.
  - S_BLOCK: all clear -> S_IDLE, no event. Otherwise stay.
- key_valid and key_release are never high in the same cycle. Each is never high for more than one cycle.
- key_code holds its last value between events.
- Latency: key_valid asserts exactly 1 cycle after the frame end at which debounced changes.
- Reset asserted mid-frame or mid-hold aborts everything; no release pulse is generated. After reset, a still-held key is re-reported after DEB_SCANS frames.
- Counter widths: $clog2 of the respective bounds. No arithmetic overflow is possible.

Test Plan:
1. Test parameters for all scenarios: SCAN_DIV=4, DEB_SCANS=3, frame=16 cycles.
2. Reset, no keys:
   - Required: col_out sequence 1110,1101,1011,0111, each held 4 cycles, repeating.
   - Required: key_valid/key_release/key_down stay 0 for 20 frames.
3. Clean press of row1/col2 (row_in=4'b1101 while col_out=1011, else 4'b1111) from frame 0 onward:
   - Required: debounced set at the end of frame 2.
   - Required: key_valid one-cycle pulse 1 cycle later, key_code=6, key_down=1.
4. Bouncy press of key 6, alternating pressed/released on frames 0-3 and then stable:
   - Required: exactly one key_valid, code 6, only after 3 stable frames.
   - Required: no key_release during the bounce.
5. Release of key 6 after hold:
   - Required: key_release pulse 3 frames after the first released frame, key_code=6, key_down=0.
   - Required: no key_valid during the release.
6. Keys 0 and 5 pressed together:
   - Required: no events; FSM in S_BLOCK.
   - Then release all and press key 15: required no release pulse, then key_valid with code 15.
7. rst pulsed while key 15 is held:
   - Required: outputs immediately at reset values, col_out=1110.
   - After rst deasserts with key still held: key_valid code 15 after 3 frames.

Source files
------------

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: walks an active-low column strobe, samples rows once per column dwell,
// debounces whole frames and reports single-key press/release events.
module key_matrix_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SCANS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HELD  = 2'd1;
  localparam logic [1:0] S_BLOCK = 2'd2;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [15:0]   snap;
  logic [15:0]   snap_next;
  logic [15:0]   prev;
  logic [15:0]   deb;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    state;
  logic          frame_done;
  logic          sample;
  logic          frame_end;
  logic          one_hot;
  logic [3:0]    key_idx;
  logic [15:0]   held_mask;

  assign sample    = (div_cnt == DIV_LAST);
  assign frame_end = sample && (col == 2'd3);
  assign col_out   = ~(4'b0001 << col);

  // The frame-end comparison must see the column-3 rows being captured this very cycle.
  always_comb begin
    snap_next = snap;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[4*r + int'(col)] = ~row_in[r];
      end
    end
  end

  always_comb begin
    cnt_next = '0;
    if (snap_next == prev) begin
      cnt_next = (stab_cnt == CNT_LAST) ? CNT_LAST : stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      col        <= 2'd0;
      snap       <= '0;
      prev       <= '0;
      deb        <= '0;
      stab_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= sample ? '0 : div_cnt + 1'b1;
      snap       <= snap_next;
      frame_done <= frame_end;
      if (sample) begin
        col <= col + 2'd1;
      end
      if (frame_end) begin
        prev     <= snap_next;
        stab_cnt <= cnt_next;
        if (cnt_next == CNT_LAST) begin
          deb <= snap_next;
        end
      end
    end
  end

  assign one_hot   = (deb != 16'h0) && ((deb & (deb - 16'h1)) == 16'h0);
  assign held_mask = 16'h0001 << key_code;

  always_comb begin
    key_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (deb[i]) begin
        key_idx = 4'(i);
      end
    end
  end

  // Events are decided one cycle after the frame end, from the freshly debounced frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_down    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (one_hot) begin
              key_code  <= key_idx;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              state     <= S_HELD;
            end else if (deb != 16'h0) begin
              state <= S_BLOCK;
            end
          end
          S_HELD: begin
            if (deb == 16'h0) begin
              key_release <= 1'b1;
              key_down    <= 1'b0;
              state       <= S_IDLE;
            end else if (deb != held_mask) begin
              key_down <= 1'b0;
              state    <= S_BLOCK;
            end
          end
          S_BLOCK: begin
            if (deb == 16'h0) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a keypad model drives rows from a pressed-key mask; expected
// events (kind, code, arrival cycle) are queued per scenario and matched by an event monitor.
module tb_key_matrix_scan;

  localparam int SD    = 4;
  localparam int DS    = 3;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_down;

  logic [15:0] pressed = 16'h0;
  int          cyc;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic       rel;
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  key_matrix_scan #(.SCAN_DIV(SD), .DEB_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // cyc is the index of the current cycle since reset release, as seen at the falling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && (key_valid || key_release)) begin
      vectors++;
      if (key_valid && key_release) begin
        miscompares++;
        $display("FAIL event_overlap: valid=%b release=%b at cyc %0d, required never both high", key_valid, key_release, cyc);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: valid=%b release=%b code=%0d at cyc %0d, required none", key_valid, key_release, key_code, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (key_release !== e.rel || key_code !== e.code || cyc !== e.at || key_down !== !e.rel) begin
          miscompares++;
          $display("FAIL event: got rel=%b code=%0d cyc=%0d down=%b, required rel=%b code=%0d cyc=%0d down=%b",
                   key_release, key_code, cyc, key_down, e.rel, e.code, e.at, !e.rel);
        end
      end
    end
  end

  task automatic goto_frame(input int f);
    while (cyc < FRAME * f) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    while (sb.size() != 0 && cyc < limit) @(negedge clk);
  endtask

  task automatic push_event(input logic rel, input logic [3:0] code, input int at);
    exp_t e;
    e.rel = rel; e.code = code; e.at = at;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_release !== 1'b0 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: col=%b code=%0d valid=%b rel=%b down=%b, required 1110 0 0 0 0",
               col_out, key_code, key_valid, key_release, key_down);
    end
    rst = 1'b0;
    for (int n = 0; n < 20 * FRAME; n++) begin
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
      vectors++;
      if (col_out !== exp_col || key_down !== 1'b0 || key_valid !== 1'b0 || key_release !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_scan: cyc=%0d col=%b down=%b valid=%b rel=%b, required col=%b and 0 0 0",
                 cyc, col_out, key_down, key_valid, key_release, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clean_press;
    goto_frame(21);
    pressed = 16'h0040;
    push_event(1'b0, 4'd6, FRAME * 24 + 1);
    wait_drain(FRAME * 27);
    vectors++;
    if (sb.size() != 0 || key_down !== 1'b1 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL clean_press: pending=%0d down=%b code=%0d, required 0 1 6", sb.size(), key_down, key_code);
      sb.delete();
    end
  endtask

  task automatic test_release(input int f);
    goto_frame(f);
    pressed = 16'h0000;
    push_event(1'b1, 4'd6, FRAME * (f + 3) + 1);
    wait_drain(FRAME * (f + 6));
    vectors++;
    if (sb.size() != 0 || key_down !== 1'b0 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL release: pending=%0d down=%b code=%0d, required 0 0 6", sb.size(), key_down, key_code);
      sb.delete();
    end
  endtask

  task automatic test_bouncy_press;
    for (int i = 0; i < 4; i++) begin
      goto_frame(33 + i);
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    goto_frame(37);
    vectors++;
    if (key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_quiet: down=%b, required 0", key_down);
    end
    pressed = 16'h0040;
    push_event(1'b0, 4'd6, FRAME * 40 + 1);
    wait_drain(FRAME * 43);
    vectors++;
    if (sb.size() != 0 || key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL bouncy_press: pending=%0d down=%b, required 0 1", sb.size(), key_down);
      sb.delete();
    end
  endtask

  task automatic test_multi_key;
    goto_frame(50);
    pressed = 16'h0021;
    goto_frame(56);
    vectors++;
    if (key_down !== 1'b0 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL multi_block: down=%b code=%0d, required 0 6", key_down, key_code);
    end
    pressed = 16'h0000;
    goto_frame(60);
    pressed = 16'h8000;
    push_event(1'b0, 4'd15, FRAME * 63 + 1);
    wait_drain(FRAME * 66);
    vectors++;
    if (sb.size() != 0 || key_down !== 1'b1 || key_code !== 4'd15) begin
      miscompares++;
      $display("FAIL after_block_press: pending=%0d down=%b code=%0d, required 0 1 15", sb.size(), key_down, key_code);
      sb.delete();
    end
  endtask

  task automatic test_reset_held;
    goto_frame(67);
    repeat (5) @(negedge clk);
    vectors++;
    if (key_down !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_held: down=%b, required 1", key_down);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_release !== 1'b0 || key_down !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: col=%b code=%0d valid=%b rel=%b down=%b, required 1110 0 0 0 0",
               col_out, key_code, key_valid, key_release, key_down);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_event(1'b0, 4'd15, FRAME * 3 + 1);
    wait_drain(FRAME * 6);
    vectors++;
    if (sb.size() != 0 || key_down !== 1'b1 || key_code !== 4'd15) begin
      miscompares++;
      $display("FAIL re_report: pending=%0d down=%b code=%0d, required 0 1 15", sb.size(), key_down, key_code);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release(28);
    test_bouncy_press();
    test_release(44);
    test_multi_key();
    test_reset_held();
    repeat (2 * FRAME) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
